// File: rtl/sram_pkg.sv
// Shared types and constants for the sram_pipe memory model.
package sram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int BYTE_W     = 8;

endpackage

// File: rtl/sram_rd_pipe.sv
// Read return line: RD_LAT stages of {valid, err, data}, then the output
// registers, where DOUT only reloads on a valid read.
module sram_rd_pipe #(
    parameter int BW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_err,
    input  logic [BW-1:0] in_data,
    output logic [BW-1:0] dout,
    output logic          dvalid,
    output logic          err
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] err_q, err_d;
    logic [BW-1:0]     dat_q [RD_LAT];
    logic [BW-1:0]     dat_d [RD_LAT];
    logic [BW-1:0]     dout_q, dout_d;
    logic              dvalid_q, dvalid_d;
    logic              err_out_q, err_out_d;

    always_comb begin
        vld_d    = '0;
        err_d    = '0;
        dat_d    = '{default: '0};
        vld_d[0] = in_valid;
        err_d[0] = in_err;
        dat_d[0] = in_data;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        dvalid_d  = vld_q[RD_LAT-1];
        err_out_d = vld_q[RD_LAT-1] & err_q[RD_LAT-1];
        dout_d    = vld_q[RD_LAT-1] ? dat_q[RD_LAT-1] : dout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            err_q     <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
            dout_q    <= '0;
            dvalid_q  <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
            dout_q    <= dout_d;
            dvalid_q  <= dvalid_d;
            err_out_q <= err_out_d;
        end
    end

    assign dout   = dout_q;
    assign dvalid = dvalid_q;
    assign err    = err_out_q;

endmodule

// File: rtl/sram_pipe.sv
// Single-port synchronous memory with byte enables, pipelined reads and a
// clear engine that fills the array with FILL after reset and on INIT.
module sram_pipe
    import sram_pkg::*;
#(
    parameter int          BW     = 32,
    parameter int          AW     = 4,
    parameter int          ENTRY  = 16,
    parameter int          RD_LAT = 1,
    parameter logic [BW-1:0] FILL = '0
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            CSN,
    input  logic            WEN,
    input  logic [AW-1:0]   A,
    input  logic [BW-1:0]   DI,
    input  logic [BW/8-1:0] BE,
    input  logic            INIT,
    output logic            READY,
    output logic [BW-1:0]   DOUT,
    output logic            DVALID,
    output logic            ERR
);

    localparam int            NB      = BW / BYTE_W;
    localparam int            IW      = (ENTRY > 1) ? $clog2(ENTRY) : 1;
    localparam logic [AW:0]   ENTRY_W = (AW+1)'(ENTRY);
    localparam logic [AW-1:0] LAST    = AW'(ENTRY - 1);

    if (BW <= 0 || (BW % BYTE_W) != 0) begin : g_chk_bw
        $error("sram_pipe: BW must be a positive multiple of 8");
    end
    if (ENTRY < 1 || ENTRY > (2 ** AW)) begin : g_chk_entry
        $error("sram_pipe: ENTRY must lie in 1..2**AW");
    end
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_chk_lat
        $error("sram_pipe: RD_LAT out of range");
    end

    logic [BW-1:0] ram_q [ENTRY];

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;

    logic          accept, a_in_range;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_wd;
    logic [NB-1:0] mem_be;
    logic          rd_valid, rd_err;
    logic [BW-1:0] rd_data;

    assign accept     = (state_q == ST_IDLE) && !CSN;
    assign a_in_range = ({1'b0, A} < ENTRY_W);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_we   = 1'b0;
        mem_addr = A;
        mem_wd   = DI;
        mem_be   = BE;
        unique case (state_q)
            ST_CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = cnt_q;
                mem_wd   = FILL;
                mem_be   = '1;
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                mem_we = accept && !WEN && a_in_range;
                // The access on this edge still completes before the clear starts.
                if (INIT) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Array has no reset; the clear engine gives it deterministic contents.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    ram_q[mem_addr[IW-1:0]][i*BYTE_W +: BYTE_W] <= mem_wd[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rd_valid = accept && WEN;
    assign rd_err   = !a_in_range;
    assign rd_data  = a_in_range ? ram_q[A[IW-1:0]] : '0;

    sram_rd_pipe #(
        .BW     (BW),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk      (CLK),
        .rst_n    (RSTN),
        .in_valid (rd_valid),
        .in_err   (rd_err),
        .in_data  (rd_data),
        .dout     (DOUT),
        .dvalid   (DVALID),
        .err      (ERR)
    );

    assign READY = ready_q;

endmodule
